// File: rtl/addr2xy.sv
// Converts a linear frame-buffer address back to (x, y) pixel coordinates
// with a bit-serial restoring divider (one quotient bit per clock).
module addr2xy #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int ADDR_W = 14,
  parameter int XY_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XY_W-1:0]   x,
  output logic [XY_W-1:0]   y,
  output logic              err
);

  localparam int REM_W = $clog2(WIDTH) + 1;
  localparam int T_W   = REM_W + 1;
  localparam int CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int CMP_W = ADDR_W + XY_W;

  localparam logic [T_W-1:0]   DIVISOR = T_W'(WIDTH);
  localparam logic [CMP_W-1:0] LIMIT   = CMP_W'(longint'(WIDTH) * longint'(HEIGHT));
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ADDR_W - 1);

  // Configuration sanity: y would silently lose quotient bits otherwise.
  if (ADDR_W > XY_W) begin : g_bad_addr_w
    $error("addr2xy: ADDR_W (%0d) exceeds XY_W (%0d); y would be truncated", ADDR_W, XY_W);
  end
  if (WIDTH < 1 || longint'(WIDTH) >= (longint'(1) << XY_W)) begin : g_bad_width
    $error("addr2xy: WIDTH (%0d) out of range for XY_W (%0d)", WIDTH, XY_W);
  end

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] q;
  logic [ADDR_W-1:0] q_nxt;
  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [T_W-1:0]    t;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = DIV;
      DIV:     if (cnt == '0)  state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // One restoring-division step; rem < WIDTH always, so t < 2*WIDTH fits T_W.
  always_comb begin
    t       = {rem, a[cnt]};
    q_nxt   = q;
    rem_nxt = rem;
    if (t >= DIVISOR) begin
      rem_nxt    = REM_W'(t - DIVISOR);
      q_nxt[cnt] = 1'b1;
    end else begin
      rem_nxt    = REM_W'(t);
      q_nxt[cnt] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      rem       <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a   <= addr;
            q   <= '0;
            rem <= '0;
            cnt <= CNT_TOP;
            err <= ({{XY_W{1'b0}}, addr} >= LIMIT);
          end
        end
        DIV: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          if (cnt == '0) begin
            x         <= XY_W'(rem_nxt);
            y         <= XY_W'(q_nxt);
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr2xy.sv
// Scoreboard bench for addr2xy: three builds (WIDTH 100, 1, 64) driven in
// lockstep, results compared against an integer % and / reference.
module tb_addr2xy;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic [13:0] addr      = '0;
  logic        man_rdy   = 1'b1;
  logic        rand_mode = 1'b0;
  logic        rr        = 1'b0;
  logic        out_ready;

  assign out_ready = rand_mode ? rr : man_rdy;

  logic        in_ready,  out_valid,  err;
  logic [15:0] x, y;
  logic        w1_in_ready, w1_out_valid, w1_err;
  logic [15:0] w1_x, w1_y;
  logic        w64_in_ready, w64_out_valid, w64_err;
  logic [15:0] w64_x, w64_y;

  addr2xy #(.WIDTH(100), .HEIGHT(100), .ADDR_W(14), .XY_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y), .err(err)
  );

  addr2xy #(.WIDTH(1), .HEIGHT(100), .ADDR_W(14), .XY_W(16)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w1_in_ready), .addr(addr),
    .out_valid(w1_out_valid), .out_ready(out_ready), .x(w1_x), .y(w1_y), .err(w1_err)
  );

  addr2xy #(.WIDTH(64), .HEIGHT(100), .ADDR_W(14), .XY_W(16)) dut_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w64_in_ready), .addr(addr),
    .out_valid(w64_out_valid), .out_ready(out_ready), .x(w64_x), .y(w64_y), .err(w64_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rr = ($urandom_range(0, 9) < 7);
  end

  int vectors     = 0;
  int miscompares = 0;
  int n_acc       = 0;
  int n_res       = 0;

  typedef struct {
    int x0, y0, e0;
    int x1, y1, e1;
    int x2, y2, e2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic exp_t model(input int a);
    exp_t e;
    e.x0 = a % 100; e.y0 = a / 100; e.e0 = (a >= 10000) ? 1 : 0;
    e.x1 = 0;       e.y1 = a;       e.e1 = (a >= 100)   ? 1 : 0;
    e.x2 = a % 64;  e.y2 = a / 64;  e.e2 = (a >= 6400)  ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(model(int'(addr)));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_res++;
        check("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("x",       int'(x),       mon_e.x0);
          check("y",       int'(y),       mon_e.y0);
          check("err",     int'(err),     mon_e.e0);
          check("w1_vld",  int'(w1_out_valid),  1);
          check("w1_x",    int'(w1_x),    mon_e.x1);
          check("w1_y",    int'(w1_y),    mon_e.y1);
          check("w1_err",  int'(w1_err),  mon_e.e1);
          check("w64_vld", int'(w64_out_valid), 1);
          check("w64_x",   int'(w64_x),   mon_e.x2);
          check("w64_y",   int'(w64_y),   mon_e.y2);
          check("w64_err", int'(w64_err), mon_e.e2);
        end
      end
    end
  end

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_wait", int'(got), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [13:0] a);
    addr     = a;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", int'(ok), 1);
  endtask

  task automatic wait_out_valid(output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("out_valid_wait", int'(ok), 1);
  endtask

  initial begin
    int lat;
    int base_acc;
    int base_res;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x",         int'(x),         0);
    check("rst_y",         int'(y),         0);
    check("rst_err",       int'(err),       0);
    check("rst_in_ready",  int'(in_ready),  1);

    // Latency from accept edge to first out_valid
    send(14'd250);
    wait_out_valid(lat);
    check("latency", lat, 14);
    drain();

    // Boundary addresses, back to back
    send(14'd0);
    send(14'd9999);
    send(14'd10000);
    send(14'd16383);
    send(14'd37);
    send(14'd200);
    drain();

    // Consumer stalls: result holds, no new accept while DONE
    man_rdy = 1'b0;
    send(14'd9999);
    wait_out_valid(lat);
    addr     = 14'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_x",     int'(x),         99);
      check("hold_y",     int'(y),         99);
      check("hold_err",   int'(err),       0);
      check("hold_busy",  int'(in_ready),  0);
    end
    man_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready),  1);
    wait_accept();
    drain();

    // Reset in the middle of a division
    send(14'd16383);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_x",     int'(x),         0);
    check("midrst_y",     int'(y),         0);
    check("midrst_err",   int'(err),       0);
    check("midrst_ready", int'(in_ready),  1);
    send(14'd101);
    drain();

    // Random sweep with a randomly stalling consumer
    base_acc  = n_acc;
    base_res  = n_res;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(14'($urandom_range(0, 16383)));
    end
    drain();
    rand_mode = 1'b0;
    check("sweep_accepts", n_acc - base_acc, 1000);
    check("sweep_results", n_res - base_res, n_acc - base_acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
